mem_arbiter: RTL and testbench

//  Shares the single byte-wide RAM port between instruction fetch (IF) and the MEM stage.

---
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Byte-wide RAM port arbiter: serialises IF word fetches and MEM 1/2/4-byte
// little-endian loads/stores into single-byte RAM transfers, MEM first.
module mem_arbiter #(
   parameter int ADDR_W = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy_in,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_done,
   output logic [31:0]       if_inst,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [1:0]        mem_size,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_wdata,
   output logic              mem_done,
   output logic [31:0]       mem_rdata,
   input  logic [7:0]        ram_din,
   output logic [7:0]        ram_dout,
   output logic [ADDR_W-1:0] ram_a,
   output logic              ram_wr
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RD   = 2'd1;
   localparam logic [1:0] S_WR   = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]        r_state;
   logic [2:0]        r_cnt;
   logic [2:0]        r_n;
   logic              r_own_mem;
   logic [ADDR_W-1:0] r_ram_a;
   logic [7:0]        r_dout;
   logic [31:0]       r_wdata;
   logic [31:0]       r_buf;
   logic [31:0]       r_if_inst;
   logic [31:0]       r_mem_rdata;
   logic [7:0]        r_hold;
   logic              r_held;

   logic [2:0]        w_mem_n;
   logic [7:0]        w_din;
   logic [31:0]       w_buf;

   // The byte returned during the first frozen cycle belongs to the last live
   // address; keep it, since later frozen cycles return the next address's byte.
   always_comb begin
      w_din = r_held ? r_hold : ram_din;
      w_buf = r_buf;
      case (r_cnt)
         3'd1:    w_buf[7:0]   = w_din;
         3'd2:    w_buf[15:8]  = w_din;
         3'd3:    w_buf[23:16] = w_din;
         3'd4:    w_buf[31:24] = w_din;
         default: ;
      endcase
   end

   always_comb begin
      case (mem_size)
         2'd0:    w_mem_n = 3'd1;
         2'd1:    w_mem_n = 3'd2;
         default: w_mem_n = 3'd4;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_n         <= '0;
         r_own_mem   <= 1'b0;
         r_ram_a     <= '0;
         r_dout      <= '0;
         r_wdata     <= '0;
         r_buf       <= '0;
         r_if_inst   <= '0;
         r_mem_rdata <= '0;
         r_hold      <= '0;
         r_held      <= 1'b0;
      end else begin
         r_held <= ~rdy_in;
         if (!rdy_in && !r_held)
            r_hold <= ram_din;
         if (rdy_in) begin
            case (r_state)
               S_IDLE: begin
                  r_cnt <= '0;
                  r_buf <= '0;
                  if (mem_req) begin
                     r_own_mem <= 1'b1;
                     r_ram_a   <= mem_addr;
                     r_n       <= w_mem_n;
                     r_wdata   <= mem_wdata;
                     if (mem_we) begin
                        r_dout  <= mem_wdata[7:0];
                        r_state <= S_WR;
                     end else begin
                        r_state <= S_RD;
                     end
                  end else if (if_req) begin
                     r_own_mem <= 1'b0;
                     r_ram_a   <= if_addr;
                     r_n       <= 3'd4;
                     r_state   <= S_RD;
                  end
               end
               S_RD: begin
                  if (!r_own_mem && !if_req) begin
                     r_state <= S_IDLE;
                  end else begin
                     if (r_cnt != 3'd0)
                        r_buf <= w_buf;
                     if (r_cnt < r_n - 3'd1)
                        r_ram_a <= r_ram_a + ADDR_W'(1);
                     if (r_cnt == r_n) begin
                        r_state <= S_DONE;
                        if (r_own_mem)
                           r_mem_rdata <= w_buf;
                        else
                           r_if_inst <= w_buf;
                     end
                     r_cnt <= r_cnt + 3'd1;
                  end
               end
               S_WR: begin
                  if (r_cnt == r_n - 3'd1) begin
                     r_state <= S_DONE;
                  end else begin
                     r_ram_a <= r_ram_a + ADDR_W'(1);
                     r_wdata <= r_wdata >> 8;
                     r_dout  <= r_wdata[15:8];
                  end
                  r_cnt <= r_cnt + 3'd1;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign ram_a     = r_ram_a;
   assign ram_dout  = r_dout;
   assign ram_wr    = (r_state == S_WR) && rdy_in;
   assign if_done   = (r_state == S_DONE) && rdy_in && !r_own_mem;
   assign mem_done  = (r_state == S_DONE) && rdy_in && r_own_mem;
   assign if_inst   = r_if_inst;
   assign mem_rdata = r_mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte RAM model, shadow memory reference and
// latency rules counted in live (rdy_in=1) cycles from the grant cycle.
module tb_mem_arbiter;

   localparam int AW    = 17;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          rdy_in = 1'b1;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic          mem_req = 1'b0;
   logic          mem_we = 1'b0;
   logic [1:0]    mem_size = '0;
   logic [AW-1:0] mem_addr = '0;
   logic [31:0]   mem_wdata = '0;
   logic [7:0]    ram_din = '0;
   logic          if_done, mem_done, ram_wr;
   logic [31:0]   if_inst, mem_rdata;
   logic [7:0]    ram_dout;
   logic [AW-1:0] ram_a;

   logic [7:0]    ram    [DEPTH];
   logic [7:0]    shadow [DEPTH];
   logic          tb_clr = 1'b0;
   logic          pl_en = 1'b0;
   logic [AW-1:0] pl_addr = '0;
   logic [7:0]    pl_data = '0;

   int n_checks = 0;
   int n_fail   = 0;

   mem_arbiter #(.ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .rdy_in(rdy_in),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
      .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
      .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] fill(input int a);
      return 8'((a * 37) ^ (a >> 9));
   endfunction

   always @(posedge clk) begin
      if (tb_clr) begin
         for (int i = 0; i < DEPTH; i++) ram[i] <= fill(i);
      end else if (pl_en) begin
         ram[pl_addr] <= pl_data;
      end else if (ram_wr) begin
         ram[ram_a] <= ram_dout;
      end
      ram_din <= ram[ram_a];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      shadow[a] = d;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   // One request from cycle 0 to completion; stall[c]=1 freezes cycle c.
   task automatic run_txn(input bit is_mem, input bit we, input logic [1:0] sz,
                          input logic [AW-1:0] addr, input logic [31:0] wd,
                          input logic [15:0] stall, output int done_cyc);
      int n, dlat, live, cyc;
      bit got, st;
      logic [31:0]   exp_d;
      logic [AW-1:0] ea;
      n    = !is_mem ? 4 : (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      st   = is_mem && we;
      dlat = st ? n + 1 : n + 2;
      exp_d = '0;
      for (int b = 0; b < n; b++) begin
         ea = addr + AW'(b);
         exp_d[8*b +: 8] = shadow[ea];
      end
      done_cyc = -1;
      rdy_in = 1'b1;
      if (is_mem) begin
         mem_req = 1'b1; mem_we = we; mem_size = sz; mem_addr = addr; mem_wdata = wd;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      @(negedge clk);
      chk("c0_wr", ram_wr, 0);
      chk("c0_done", {if_done, mem_done}, 0);
      live = 0; cyc = 0; got = 0;
      while (!got && cyc < 64) begin
         @(posedge clk); #1;
         cyc++;
         rdy_in = (cyc < 16) ? !stall[cyc] : 1'b1;
         @(negedge clk);
         if (!rdy_in) begin
            chk("frz_wr", ram_wr, 0);
            chk("frz_done", {if_done, mem_done}, 0);
         end else begin
            live++;
            if (live <= n) begin
               ea = addr + AW'(live) - AW'(1);
               chk("ram_a", ram_a, ea);
            end
            chk("ram_wr", ram_wr, st && live <= n);
            if (st && live <= n) chk("ram_dout", ram_dout, wd[8*(live-1) +: 8]);
            chk("if_done", if_done, !is_mem && live == dlat);
            chk("mem_done", mem_done, is_mem && live == dlat);
            if (live == dlat) begin
               got = 1;
               done_cyc = cyc;
               if (!st) chk("rdata", is_mem ? mem_rdata : if_inst, exp_d);
            end
         end
      end
      chk("timeout", got, 1);
      @(posedge clk); #1;
      rdy_in = 1'b1; if_req = 1'b0; mem_req = 1'b0;
      if (st) begin
         for (int b = 0; b < n; b++) begin
            ea = addr + AW'(b);
            shadow[ea] = wd[8*b +: 8];
         end
      end
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: got=running exp=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int dc, md, id, fa, nmd, nid, a4, a5;
      bit both;
      logic [31:0]   saved;
      logic [15:0]   stall;
      logic [AW-1:0] ra;
      int kind;

      for (int i = 0; i < DEPTH; i++) shadow[i] = fill(i);
      tb_clr = 1'b1;
      @(posedge clk); #1;
      tb_clr = 1'b0;
      chk("rst_ram_a", ram_a, 0);
      chk("rst_dout", ram_dout, 0);
      chk("rst_inst", if_inst, 0);
      chk("rst_rdata", mem_rdata, 0);
      chk("rst_strobes", {ram_wr, if_done, mem_done}, 0);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;

      // IF word fetch
      preload(17'h100, 8'h13); preload(17'h101, 8'h00);
      preload(17'h102, 8'h00); preload(17'h103, 8'h00);
      run_txn(0, 0, 2'd0, 17'h100, 32'h0, 16'h0, dc);
      chk("t1_done_cyc", dc, 6);
      chk("t1_inst", if_inst, 32'h0000_0013);

      // word store
      run_txn(1, 1, 2'd2, 17'h01000, 32'hDEAD_BEEF, 16'h0, dc);
      chk("t2_done_cyc", dc, 5);

      // simultaneous requests: MEM byte load first, then IF
      preload(17'h20, 8'h9C);
      preload(17'h300, 8'h78); preload(17'h301, 8'h56);
      preload(17'h302, 8'h34); preload(17'h303, 8'h12);
      rdy_in = 1'b1;
      if_req = 1'b1; if_addr = 17'h300;
      mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd0; mem_addr = 17'h20;
      md = -1; id = -1; fa = -1; nmd = 0; nid = 0; both = 0;
      for (int c = 1; c <= 16; c++) begin
         @(posedge clk); #1;
         if (md >= 0) mem_req = 1'b0;
         if (id >= 0) if_req = 1'b0;
         @(negedge clk);
         if (mem_done) begin nmd++; if (md < 0) md = c; end
         if (if_done)  begin nid++; if (id < 0) id = c; end
         if (ram_a == 17'h300 && fa < 0) fa = c;
         if (if_done && mem_done) both = 1;
      end
      @(posedge clk); #1;
      chk("t3_mem_done_cyc", md, 3);
      chk("t3_rdata", mem_rdata, 32'h0000_009C);
      chk("t3_if_first_a", fa, 5);
      chk("t3_if_done_cyc", id, 10);
      chk("t3_inst", if_inst, 32'h1234_5678);
      chk("t3_done_counts", {nmd[3:0], nid[3:0]}, 8'h11);
      chk("t3_both_done", both, 0);

      // IF abort with MEM request arriving in the same cycle
      saved = if_inst;
      if_req = 1'b1; if_addr = 17'h400;
      md = -1; nid = 0; a4 = -1; a5 = -1;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #1;
         if (c == 3) begin
            if_req = 1'b0;
            mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd0; mem_addr = 17'h500;
         end
         if (md >= 0) mem_req = 1'b0;
         @(negedge clk);
         if (c == 4) a4 = int'(ram_a);
         if (c == 5) a5 = int'(ram_a);
         if (mem_done && md < 0) md = c;
         if (if_done) nid++;
      end
      @(posedge clk); #1;
      chk("t4_hold_a", a4, 32'h402);
      chk("t4_mem_first_a", a5, 32'h500);
      chk("t4_mem_done_cyc", md, 7);
      chk("t4_no_if_done", nid, 0);
      chk("t4_inst_kept", if_inst, saved);
      chk("t4_rdata", mem_rdata, {24'h0, shadow[17'h500]});

      // stall cycles 2-3 of an IF fetch
      run_txn(0, 0, 2'd0, 17'h100, 32'h0, 16'h000C, dc);
      chk("t5_done_cyc", dc, 8);
      chk("t5_inst", if_inst, 32'h0000_0013);

      // async reset during a wrapping half store
      mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd1; mem_addr = 17'h1FFFF; mem_wdata = 32'h0000_BEEF;
      @(posedge clk); #1;
      chk("t6_a_c1", ram_a, 17'h1FFFF);
      chk("t6_wr_c1", ram_wr, 1);
      #2 rst = 1'b0;
      #1;
      chk("t6_rst_wr", ram_wr, 0);
      chk("t6_rst_a", ram_a, 0);
      chk("t6_rst_dout", ram_dout, 0);
      chk("t6_rst_data", if_inst | mem_rdata, 0);
      chk("t6_rst_done", {if_done, mem_done}, 0);
      mem_req = 1'b0;
      @(negedge clk); @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      run_txn(1, 1, 2'd1, 17'h1FFFF, 32'h0000_BEEF, 16'h0, dc);
      chk("t6_done_cyc", dc, 3);
      run_txn(1, 0, 2'd1, 17'h1FFFF, 32'h0, 16'h0, dc);
      chk("t6_wrap_load", mem_rdata, 32'h0000_BEEF);

      // randomized traffic
      for (int t = 0; t < 40; t++) begin
         kind  = $urandom_range(0, 2);
         ra    = AW'($urandom_range(0, DEPTH - 1));
         if ($urandom_range(0, 4) == 0) ra = 17'h1FFFF - AW'($urandom_range(0, 2));
         stall = 16'($urandom & $urandom) & 16'hFFFE;
         run_txn(kind != 0, kind == 2, 2'($urandom_range(0, 3)), ra, $urandom, stall, dc);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
